// File: rtl/snake_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snake_clk_pkg
// Brief   : Clock constants, half-period helpers and default channel setup
//           shared by the Snake tick generator.
// Rev     : 1.0 - initial release
// ============================================================================
package snake_clk_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned c_def_cnt_w = 26;

    // Half-period in system clock cycles for a square wave of the given rate.
    function automatic int unsigned hz_to_half(input int unsigned hz);
        return CLK_HZ / (2 * hz);
    endfunction

    // Select-bus width for a channel count; a single channel still gets one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic [c_def_cnt_w-1:0] c_half_2hz = c_def_cnt_w'(hz_to_half(2));
    localparam logic [c_def_cnt_w-1:0] c_half_4hz = c_def_cnt_w'(hz_to_half(4));
    localparam logic [c_def_cnt_w-1:0] c_half_8hz = c_def_cnt_w'(hz_to_half(8));

    localparam logic [3*c_def_cnt_w-1:0] c_default_half_3ch =
        {c_half_8hz, c_half_4hz, c_half_2hz};

endpackage : snake_clk_pkg
`default_nettype wire

// File: rtl/snake_tick_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : snake_tick_gen_if
// Brief   : Control/output bundle of the tick generator. The sync signal only
//           exists when TICK_GEN_PHASE_SYNC_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
interface snake_tick_gen_if
    import snake_clk_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 26
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] en;
    logic              boost;
    logic              div_we;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_data;
`ifdef TICK_GEN_PHASE_SYNC_EN
    logic              sync;
`endif
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

`ifdef TICK_GEN_PHASE_SYNC_EN
    modport master (
        output en, boost, div_we, div_sel, div_data, sync,
        input  clk_out, tick
    );
    modport slave (
        input  en, boost, div_we, div_sel, div_data, sync,
        output clk_out, tick
    );
`else
    modport master (
        output en, boost, div_we, div_sel, div_data,
        input  clk_out, tick
    );
    modport slave (
        input  en, boost, div_we, div_sel, div_data,
        output clk_out, tick
    );
`endif

endinterface : snake_tick_gen_if
`default_nettype wire

// File: rtl/snake_tick_ch.sv
`default_nettype none
// ============================================================================
// Module  : snake_tick_ch
// Brief   : One tick channel: counter, active/shadow half-period, square wave
//           and a one-cycle tick on each rising edge of the wave.
// Rev     : 1.0 - initial release
// ============================================================================
module snake_tick_ch #(
    parameter int               CNT_W        = 26,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = '1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_boost,
    input  wire logic             i_sync,
    input  wire logic             i_we,
    input  wire logic [CNT_W-1:0] i_wdata,
    output logic                  o_clk_out,
    output logic                  o_tick
);

    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_reset_half = (DEFAULT_HALF == '0) ? c_one : DEFAULT_HALF;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_half_boost;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_shadow_nxt;
    logic             w_tc;

    // A write landing on the terminal-count cycle must be the value loaded,
    // so the reload source is the post-write shadow, not the stored one.
    always_comb begin
        w_half_boost = r_active >> 1;
        if (w_half_boost == '0) begin
            w_half_boost = c_one;
        end
        w_half       = i_boost ? w_half_boost : r_active;
        w_shadow_nxt = i_we ? i_wdata : r_shadow;
        // >= rather than == so a boost shrinking H mid-phase ends it at once.
        w_tc         = (r_cnt >= (w_half - c_one));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_active  <= c_reset_half;
            r_shadow  <= c_reset_half;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_sync) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                r_active  <= w_shadow_nxt;
            end else if (!i_en) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_tc) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= ~r_clk_out;
                r_active  <= w_shadow_nxt;
            end else begin
                r_cnt     <= r_cnt + c_one;
                r_tick    <= 1'b0;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule : snake_tick_ch
`default_nettype wire

// File: rtl/snake_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : snake_tick_gen
// Brief   : Multi-channel square-wave/tick generator with run-time reloadable
//           half-periods and boost. Option macro: TICK_GEN_PHASE_SYNC_EN adds
//           a sync input that phase-aligns all channels.
// Rev     : 1.0 - initial release
// ============================================================================
module snake_tick_gen
    import snake_clk_pkg::*;
#(
    parameter int                        NUM_CH       = 3,
    parameter int                        CNT_W        = 26,
    parameter logic [NUM_CH*CNT_W-1:0]   DEFAULT_HALF = c_default_half_3ch,
    parameter logic [NUM_CH-1:0]         BOOST_MASK   = NUM_CH'(3'b010)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    snake_tick_gen_if.slave   bus
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic [CNT_W-1:0]  w_wdata;
    logic              w_sync;
    logic [NUM_CH-1:0] w_clk_out;
    logic [NUM_CH-1:0] w_tick;

    // A zero half-period would never reach terminal count; clamp to 1.
    assign w_wdata = (bus.div_data == '0) ? CNT_W'(1) : bus.div_data;

`ifdef TICK_GEN_PHASE_SYNC_EN
    assign w_sync = bus.sync;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_we;
        logic w_boost;

        assign w_we    = bus.div_we && (bus.div_sel == SEL_W'(i));
        assign w_boost = bus.boost && BOOST_MASK[i];

        snake_tick_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (bus.en[i]),
            .i_boost   (w_boost),
            .i_sync    (w_sync),
            .i_we      (w_we),
            .i_wdata   (w_wdata),
            .o_clk_out (w_clk_out[i]),
            .o_tick    (w_tick[i])
        );
    end

    assign bus.clk_out = w_clk_out;
    assign bus.tick    = w_tick;

endmodule : snake_tick_gen
`default_nettype wire
